// File: rtl/i2c_target_stretch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_target_stretch
//  Purpose  : I2C target with 1..2 byte sub-address, repeated START, digital
//             glitch filter, auto-incrementing application address and SCL
//             clock stretching while the application prepares read data.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_target_stretch #(
   parameter logic [6:0] SLAVE_ADDR    = 7'h70,
   parameter int         SUBADDR_BYTES = 1,
   parameter int         FILTER_LEN    = 3,
   parameter int         STRETCH_MAX   = 255,
   localparam int        ADDR_W        = 8 * SUBADDR_BYTES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              sda_i,
   output logic              sda_o,
   output logic              sda_oe,
   input  logic              scl_i,
   output logic              scl_o,
   output logic              scl_oe,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        wdata,
   output logic              we,
   output logic              wr_rdn,
   output logic              re,
   input  logic [7:0]        rdata,
   input  logic              rvalid,
   output logic              busy,
   output logic              rd_timeout
);

   localparam int FCNT_W = $clog2(FILTER_LEN);
   localparam int TMO_W  = $clog2(STRETCH_MAX + 1);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ADDR     = 4'd1,
      ADDR_ACK = 4'd2,
      SUB      = 4'd3,
      SUB_ACK  = 4'd4,
      WR_DATA  = 4'd5,
      WR_ACK   = 4'd6,
      RD_REQ   = 4'd7,
      RD_DATA  = 4'd8,
      RD_ACK   = 4'd9
   } state_t;

   // Open-drain pads: only the output enables ever toggle.
   assign sda_o = 1'b0;
   assign scl_o = 1'b0;

   // ------------------------------------------------------------------
   // Line conditioning. Index 0 = SDA, index 1 = SCL.
   // ------------------------------------------------------------------
   logic [1:0]        pad_in;
   logic [1:0]        sync1;
   logic [1:0]        sync2;
   logic [1:0]        filt;
   logic [1:0]        filt_d;
   logic [FCNT_W-1:0] fcnt [2];

   assign pad_in = {scl_i, sda_i};

   // Synchronise both pads and only flip a filtered level after FILTER_LEN
   // consecutive samples that disagree with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         filt   <= 2'b11;
         filt_d <= 2'b11;
         for (int i = 0; i < 2; i++) fcnt[i] <= '0;
      end else begin
         sync1  <= pad_in;
         sync2  <= sync1;
         filt_d <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != filt[i]) begin
               if (fcnt[i] == FCNT_W'(FILTER_LEN - 1)) begin
                  filt[i] <= sync2[i];
                  fcnt[i] <= '0;
               end else begin
                  fcnt[i] <= fcnt[i] + 1'b1;
               end
            end else begin
               fcnt[i] <= '0;
            end
         end
      end
   end

   logic sda_f;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign sda_f    = filt[0];
   assign scl_rise =  filt[1] & ~filt_d[1];
   assign scl_fall = ~filt[1] &  filt_d[1];
   // SCL must have been high on both sides of the SDA edge. When read data
   // is loaded, SDA may fall in the same cycle SCL is released; that must
   // not look like a START.
   assign start_det = ~sda_f &  filt_d[0] & filt[1] & filt_d[1];
   assign stop_det  =  sda_f & ~filt_d[0] & filt[1] & filt_d[1];

   // ------------------------------------------------------------------
   // Protocol FSM
   // ------------------------------------------------------------------
   state_t            state,      state_nx;
   logic [3:0]        bit_cnt,    bit_cnt_nx;
   logic [7:0]        shreg,      shreg_nx;
   logic              sub_idx,    sub_idx_nx;
   logic [TMO_W-1:0]  tmo_cnt,    tmo_cnt_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [7:0]        wdata_nx;
   logic              we_nx, re_nx, wr_rdn_nx, busy_nx, rd_timeout_nx;
   logic              sda_oe_nx, scl_oe_nx;
   logic              byte_done;

   assign byte_done = (bit_cnt == 4'd8);

   // State and datapath registers; every pad-facing output is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         sub_idx    <= 1'b0;
         tmo_cnt    <= '0;
         addr       <= '0;
         wdata      <= '0;
         we         <= 1'b0;
         re         <= 1'b0;
         wr_rdn     <= 1'b0;
         busy       <= 1'b0;
         rd_timeout <= 1'b0;
         sda_oe     <= 1'b0;
         scl_oe     <= 1'b0;
      end else begin
         state      <= state_nx;
         bit_cnt    <= bit_cnt_nx;
         shreg      <= shreg_nx;
         sub_idx    <= sub_idx_nx;
         tmo_cnt    <= tmo_cnt_nx;
         addr       <= addr_nx;
         wdata      <= wdata_nx;
         we         <= we_nx;
         re         <= re_nx;
         wr_rdn     <= wr_rdn_nx;
         busy       <= busy_nx;
         rd_timeout <= rd_timeout_nx;
         sda_oe     <= sda_oe_nx;
         scl_oe     <= scl_oe_nx;
      end
   end

   // Next-state and next-output logic; ena, START and STOP override the
   // per-state behaviour in that order.
   always_comb begin
      state_nx      = state;
      bit_cnt_nx    = bit_cnt;
      shreg_nx      = shreg;
      sub_idx_nx    = sub_idx;
      tmo_cnt_nx    = tmo_cnt;
      addr_nx       = addr;
      wdata_nx      = wdata;
      wr_rdn_nx     = wr_rdn;
      busy_nx       = busy;
      sda_oe_nx     = sda_oe;
      scl_oe_nx     = scl_oe;
      we_nx         = 1'b0;
      re_nx         = 1'b0;
      rd_timeout_nx = 1'b0;

      if (!ena) begin
         state_nx   = IDLE;
         bit_cnt_nx = '0;
         busy_nx    = 1'b0;
         sda_oe_nx  = 1'b0;
         scl_oe_nx  = 1'b0;
      end else if (start_det) begin
         state_nx   = ADDR;
         bit_cnt_nx = '0;
         sda_oe_nx  = 1'b0;
         scl_oe_nx  = 1'b0;
      end else if (stop_det) begin
         state_nx   = IDLE;
         bit_cnt_nx = '0;
         busy_nx    = 1'b0;
         sda_oe_nx  = 1'b0;
         scl_oe_nx  = 1'b0;
      end else begin
         case (state)
            IDLE: ;

            ADDR: begin
               if (scl_rise) begin
                  shreg_nx   = {shreg[6:0], sda_f};
                  bit_cnt_nx = bit_cnt + 4'd1;
               end else if (scl_fall && byte_done) begin
                  if (shreg[7:1] == SLAVE_ADDR) begin
                     state_nx  = ADDR_ACK;
                     sda_oe_nx = 1'b1;
                     busy_nx   = 1'b1;
                     wr_rdn_nx = ~shreg[0];
                  end else begin
                     state_nx = IDLE;
                     busy_nx  = 1'b0;
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_fall) begin
                  sda_oe_nx  = 1'b0;
                  bit_cnt_nx = '0;
                  if (wr_rdn) begin
                     state_nx   = SUB;
                     sub_idx_nx = 1'b0;
                  end else begin
                     state_nx   = RD_REQ;
                     re_nx      = 1'b1;
                     scl_oe_nx  = 1'b1;
                     tmo_cnt_nx = '0;
                  end
               end
            end

            SUB: begin
               if (scl_rise) begin
                  shreg_nx   = {shreg[6:0], sda_f};
                  bit_cnt_nx = bit_cnt + 4'd1;
               end else if (scl_fall && byte_done) begin
                  state_nx  = SUB_ACK;
                  sda_oe_nx = 1'b1;
               end
            end

            SUB_ACK: begin
               if (scl_fall) begin
                  sda_oe_nx  = 1'b0;
                  bit_cnt_nx = '0;
                  // Sub-address bytes arrive most significant first.
                  for (int i = 0; i < SUBADDR_BYTES; i++) begin
                     if (int'(sub_idx) == i) addr_nx[ADDR_W-1-8*i -: 8] = shreg;
                  end
                  if (int'(sub_idx) < SUBADDR_BYTES - 1) begin
                     sub_idx_nx = sub_idx + 1'b1;
                     state_nx   = SUB;
                  end else begin
                     state_nx = WR_DATA;
                  end
               end
            end

            WR_DATA: begin
               if (scl_rise) begin
                  shreg_nx   = {shreg[6:0], sda_f};
                  bit_cnt_nx = bit_cnt + 4'd1;
               end else if (scl_fall && byte_done) begin
                  state_nx  = WR_ACK;
                  sda_oe_nx = 1'b1;
                  we_nx     = 1'b1;
                  wdata_nx  = shreg;
               end
            end

            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_nx  = 1'b0;
                  bit_cnt_nx = '0;
                  addr_nx    = addr + 1'b1;
                  state_nx   = WR_DATA;
               end
            end

            RD_REQ: begin
               // SCL is held low here; rvalid may already be high with re.
               if (rvalid) begin
                  shreg_nx   = rdata;
                  sda_oe_nx  = ~rdata[7];
                  scl_oe_nx  = 1'b0;
                  bit_cnt_nx = '0;
                  state_nx   = RD_DATA;
               end else if (tmo_cnt == TMO_W'(STRETCH_MAX - 1)) begin
                  shreg_nx      = 8'hFF;
                  sda_oe_nx     = 1'b0;
                  scl_oe_nx     = 1'b0;
                  rd_timeout_nx = 1'b1;
                  bit_cnt_nx    = '0;
                  state_nx      = RD_DATA;
               end else begin
                  tmo_cnt_nx = tmo_cnt + 1'b1;
               end
            end

            RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_nx = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (byte_done) begin
                     sda_oe_nx  = 1'b0;
                     bit_cnt_nx = '0;
                     state_nx   = RD_ACK;
                  end else begin
                     shreg_nx  = {shreg[6:0], 1'b0};
                     sda_oe_nx = ~shreg[6];
                  end
               end
            end

            RD_ACK: begin
               // A NAK ends the read at once; an ACK fetches the next byte.
               if (scl_rise && sda_f) begin
                  state_nx = IDLE;
                  busy_nx  = 1'b0;
               end else if (scl_fall) begin
                  addr_nx    = addr + 1'b1;
                  state_nx   = RD_REQ;
                  re_nx      = 1'b1;
                  scl_oe_nx  = 1'b1;
                  tmo_cnt_nx = '0;
               end
            end

            default: state_nx = IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_stretch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target_stretch
//  Purpose  : Self-checking bench for i2c_target_stretch (2-byte sub-address)
//             with a bit-level bus master and an event scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_target_stretch;

   localparam int Q      = 12;
   localparam int EV_WR  = 0;
   localparam int EV_RE  = 1;
   localparam int EV_TMO = 2;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic        sda_m, scl_m;
   logic        sda_bus, scl_bus;
   logic        sda_o, sda_oe, scl_o, scl_oe;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        we, wr_rdn, re, busy, rd_timeout;
   logic [7:0]  rdata;
   logic        rvalid;

   int checks   = 0;
   int failures = 0;
   int rd_mode  = 0;
   logic sda_oe_seen = 1'b0;

   typedef struct {
      int          kind;
      logic [15:0] a;
      logic [7:0]  d;
   } ev_t;

   ev_t exp_q[$];
   int  stretch_q[$];

   assign sda_bus = sda_m & ~sda_oe;
   assign scl_bus = scl_m & ~scl_oe;

   i2c_target_stretch #(
      .SLAVE_ADDR    (7'h70),
      .SUBADDR_BYTES (2),
      .FILTER_LEN    (3),
      .STRETCH_MAX   (255)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .sda_i      (sda_bus),
      .sda_o      (sda_o),
      .sda_oe     (sda_oe),
      .scl_i      (scl_bus),
      .scl_o      (scl_o),
      .scl_oe     (scl_oe),
      .addr       (addr),
      .wdata      (wdata),
      .we         (we),
      .wr_rdn     (wr_rdn),
      .re         (re),
      .rdata      (rdata),
      .rvalid     (rvalid),
      .busy       (busy),
      .rd_timeout (rd_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic check_min(input string nm, input int got, input int lo);
      checks++;
      if (got < lo) begin
         failures++;
         $display("FAIL %s: got %0d expected at least %0d", nm, got, lo);
      end
   endtask

   task automatic push_ev(input int k, input logic [15:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k; e.a = a; e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input int k, input logic [15:0] a, input logic [7:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h expected no event", k, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.a !== a || e.d !== d) begin
            failures++;
            $display("FAIL sb_event: got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                     k, a, d, e.kind, e.a, e.d);
         end
      end
   endtask

   // Scoreboard monitor: every application-side strobe pops one expectation.
   initial begin
      forever begin
         @(posedge clk); #2;
         if (rst_n) begin
            if (we)         sb_check(EV_WR, addr, wdata);
            if (re)         sb_check(EV_RE, addr, 8'h00);
            if (rd_timeout) sb_check(EV_TMO, addr, 8'h00);
         end
      end
   end

   // Records the length of each SCL stretch and whether SDA was ever pulled.
   initial begin
      int run = 0;
      forever begin
         @(posedge clk); #2;
         if (sda_oe) sda_oe_seen = 1'b1;
         if (scl_oe) run++;
         else if (run > 0) begin
            stretch_q.push_back(run);
            run = 0;
         end
      end
   end

   // Application read responder: data = addr[7:0] ^ 8'h5A, 20 cycles after re.
   initial begin
      logic [15:0] ra;
      rvalid = 1'b0;
      rdata  = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (re && rd_mode == 0) begin
            ra = addr;
            repeat (20) @(posedge clk);
            #1;
            rvalid = 1'b1;
            rdata  = ra[7:0] ^ 8'h5A;
            @(posedge clk); #1;
            rvalid = 1'b0;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_scl_high();
      int n = 0;
      while (!scl_bus && n < 2000) begin
         cycles(1);
         n++;
      end
      if (!scl_bus) begin
         checks++;
         failures++;
         $display("FAIL scl_release: got SCL low after %0d cycles expected high", n);
      end
   endtask

   task automatic clk_bit(input logic b, input int glen, output logic s);
      sda_m = b;
      cycles(Q);
      scl_m = 1'b1;
      wait_scl_high();
      cycles(Q);
      s = sda_bus;
      if (glen > 0) begin
         sda_m = ~b;
         cycles(glen);
         sda_m = b;
      end
      cycles(Q);
      scl_m = 1'b0;
      cycles(Q);
   endtask

   task automatic do_start();
      sda_m = 1'b1; cycles(Q);
      scl_m = 1'b1; wait_scl_high(); cycles(Q);
      sda_m = 1'b0; cycles(Q);
      scl_m = 1'b0; cycles(Q);
   endtask

   task automatic do_stop();
      sda_m = 1'b0; cycles(Q);
      scl_m = 1'b1; wait_scl_high(); cycles(Q);
      sda_m = 1'b1; cycles(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, input int glen7, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == 7) ? glen7 : 0, s);
      clk_bit(1'b1, 0, s);
      ack = ~s;
   endtask

   task automatic wr(input logic [7:0] b, input string nm);
      logic ack;
      write_byte(b, 0, ack);
      check(nm, ack, 1);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nak);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, 0, s);
         d[i] = s;
      end
      clk_bit(nak, 0, s);
   endtask

   task automatic pop_stretch(output int len);
      if (stretch_q.size() == 0) len = 0;
      else len = stretch_q.pop_front();
   endtask

   initial begin
      logic [7:0] d;
      logic       ack;
      logic       s;
      int         len;
      int         n;

      rst_n = 1'b0;
      ena   = 1'b1;
      sda_m = 1'b1;
      scl_m = 1'b1;
      cycles(3);

      // Reset state
      check("rst_sda_oe", sda_oe, 0);
      check("rst_scl_oe", scl_oe, 0);
      check("rst_pads", {sda_o, scl_o}, 0);
      check("rst_addr", addr, 0);
      check("rst_strobes", {we, re, rd_timeout, wr_rdn, busy}, 0);
      check("rst_wdata", wdata, 0);
      rst_n = 1'b1;
      cycles(5);

      // Two-byte sub-address write of two data bytes
      push_ev(EV_WR, 16'h1234, 8'hAA);
      push_ev(EV_WR, 16'h1235, 8'h55);
      do_start();
      wr(8'hE0, "t1_ack_addr");
      check("t1_busy", busy, 1);
      check("t1_wr_rdn", wr_rdn, 1);
      wr(8'h12, "t1_ack_sub0");
      wr(8'h34, "t1_ack_sub1");
      wr(8'hAA, "t1_ack_d0");
      wr(8'h55, "t1_ack_d1");
      do_stop();
      check("t1_busy_after_stop", busy, 0);

      // Sub-address 0x0010, repeated START, two stretched reads
      push_ev(EV_RE, 16'h0010, 8'h00);
      push_ev(EV_RE, 16'h0011, 8'h00);
      do_start();
      wr(8'hE0, "t2_ack_addr");
      wr(8'h00, "t2_ack_sub0");
      wr(8'h10, "t2_ack_sub1");
      do_start();
      wr(8'hE1, "t2_ack_raddr");
      check("t2_wr_rdn", wr_rdn, 0);
      read_byte(d, 1'b0);
      check("t2_rd0", d, 8'h4A);
      pop_stretch(len);
      check_min("t2_stretch0", len, 20);
      read_byte(d, 1'b1);
      check("t2_rd1", d, 8'h4B);
      pop_stretch(len);
      check_min("t2_stretch1", len, 20);
      check("t2_busy_after_nak", busy, 0);
      do_stop();

      // Foreign address 0x71: no ACK, no strobes
      sda_oe_seen = 1'b0;
      do_start();
      write_byte(8'hE2, 0, ack);
      check("t3_no_ack", ack, 0);
      check("t3_sda_never_pulled", sda_oe_seen, 0);
      check("t3_busy", busy, 0);
      do_stop();

      // Read timeout: rvalid never comes
      rd_mode = 1;
      push_ev(EV_RE, 16'h0011, 8'h00);
      push_ev(EV_TMO, 16'h0011, 8'h00);
      do_start();
      wr(8'hE1, "t4_ack_raddr");
      read_byte(d, 1'b1);
      check("t4_rd_ff", d, 8'hFF);
      pop_stretch(len);
      check("t4_stretch_len", len, 255);
      do_stop();
      rd_mode = 0;

      // SDA glitches while SCL high: FILTER_LEN-1 ignored, FILTER_LEN seen
      push_ev(EV_WR, 16'h0030, 8'h3C);
      do_start();
      wr(8'hE0, "t5_ack_addr");
      wr(8'h00, "t5_ack_sub0");
      wr(8'h30, "t5_ack_sub1");
      write_byte(8'h3C, 2, ack);
      check("t5_ack_glitch2", ack, 1);
      check("t5_busy_glitch2", busy, 1);
      clk_bit(1'b0, 3, s);
      check("t5_busy_glitch3", busy, 0);
      do_stop();

      // Address wrap from 0xFFFF
      push_ev(EV_WR, 16'hFFFF, 8'h11);
      push_ev(EV_WR, 16'h0000, 8'h22);
      do_start();
      wr(8'hE0, "t6_ack_addr");
      wr(8'hFF, "t6_ack_sub0");
      wr(8'hFF, "t6_ack_sub1");
      wr(8'h11, "t6_ack_d0");
      wr(8'h22, "t6_ack_d1");
      do_stop();

      // Asynchronous reset while SCL is being stretched
      rd_mode = 1;
      push_ev(EV_RE, 16'h0001, 8'h00);
      do_start();
      wr(8'hE1, "t7_ack_raddr");
      n = 0;
      while (!scl_oe && n < 100) begin
         cycles(1);
         n++;
      end
      check("t7_stretching", scl_oe, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("t7_rst_oe", {sda_oe, scl_oe}, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_addr", addr, 0);
      check("t7_rst_strobes", {we, re, rd_timeout, wr_rdn}, 0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      cycles(4);
      rst_n = 1'b1;
      cycles(10);
      stretch_q.delete();
      rd_mode = 0;

      // Normal write after reset
      push_ev(EV_WR, 16'h0020, 8'h77);
      do_start();
      wr(8'hE0, "t8_ack_addr");
      wr(8'h00, "t8_ack_sub0");
      wr(8'h20, "t8_ack_sub1");
      wr(8'h77, "t8_ack_d0");
      do_stop();
      check("t8_busy", busy, 0);

      cycles(20);
      check("sb_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_target_stretch.md
Name: i2c_target_stretch

Overview:
Parametrised I2C target that succeeds the single-sub-address peripheral. It supports 1–2 byte sub-addresses, repeated START, a configurable glitch-filter depth, and SCL clock stretching while the application prepares read data. It sits between the pad-level SDA/SCL open-drain signals and the register-file application bus, with auto-increment of the application address on every data byte.

Parameters:
- SLAVE_ADDR, 7'h70, 7-bit target address matched against the first byte.
- SUBADDR_BYTES, 1, number of sub-address bytes (1 or 2), sent MSB byte first. ADDR_W = 8*SUBADDR_BYTES.
- FILTER_LEN, 3, number of consecutive identical samples needed to change a filtered line level (2..8).
- STRETCH_MAX, 255, maximum clk cycles SCL is held low waiting for rvalid before timeout.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous active-low.
- ena, input, 1, block enable; 0 releases both lines and forces IDLE.
- sda_i, input, 1, SDA pad input (asynchronous).
- sda_o, output, 1, constant 0 (open-drain).
- sda_oe, output, 1, 1 = pull SDA low.
- scl_i, input, 1, SCL pad input (asynchronous).
- scl_o, output, 1, constant 0.
- scl_oe, output, 1, 1 = stretch (pull SCL low).
- addr, output, ADDR_W, application address.
- wdata, output, 8, write data, valid while we=1.
- we, output, 1, one-cycle write strobe.
- wr_rdn, output, 1, 1 = current transaction is a write.
- re, output, 1, one-cycle read request for addr.
- rdata, input, 8, read data, sampled when rvalid=1.
- rvalid, input, 1, read data ready (may be asserted in the same cycle as re).
- busy, output, 1, 1 from address match until STOP, NAK or IDLE.
- rd_timeout, output, 1, one-cycle pulse on stretch timeout.

Behaviour:
- Reset values: sda_oe=0, scl_oe=0, addr=0, wdata=0, we=0, re=0, wr_rdn=0, busy=0, rd_timeout=0, state=IDLE, filtered SDA/SCL=1.
- Filter: each line is passed through a 2-flop synchroniser, then a counter. The filtered level toggles only after FILTER_LEN consecutive samples that differ from it. scl_rise, scl_fall and sda edges are one-cycle pulses derived from filtered levels only.
- START/repeated START: filtered SDA falls while filtered SCL=1. From any state it resets the bit counter and goes to ADDR. addr is preserved.
- STOP: filtered SDA rises while filtered SCL=1. From any state it goes to IDLE, busy=0, releases lines.
- Bit sampling: bits are shifted MSB first on scl_rise. Target drives sda_oe changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th scl_fall: if byte[7:1]==SLAVE_ADDR go to ADDR_ACK; otherwise go to IDLE with no ACK.
  - ADDR_ACK: sda_oe=1 until the next scl_fall; busy=1; wr_rdn=~byte[0]. At that scl_fall, a write goes to SUB with sub-byte index 0; a read goes to RD_REQ.
  - SUB: shift 8 bits, then SUB_ACK. At the ACK's scl_fall, load the byte into addr[ADDR_W-1-8*idx -: 8]. If idx < SUBADDR_BYTES-1, increment idx and return to SUB; otherwise go to WR_DATA.
  - WR_DATA: shift 8 bits. On the cycle after the 8th scl_fall, wdata=byte and we=1 for one cycle with the current addr, then go to WR_ACK.
  - WR_ACK: sda_oe=1. At scl_fall, release SDA, addr<=addr+1, go to WR_DATA.
  - RD_REQ: on entry, re=1 for one cycle and scl_oe=1 (SCL already low). Wait for rvalid, then latch rdata, set scl_oe=0 and go to RD_DATA.
    - Timeout: if STRETCH_MAX cycles elapse without rvalid, load 8'hFF, pulse rd_timeout, release SCL and go to RD_DATA.
  - RD_DATA: sda_oe = ~shift[7] immediately after loading, and after each scl_fall shift left. After the 8th scl_fall, set sda_oe=0 and go to RD_ACK.
  - RD_ACK: sample SDA at scl_rise. ACK (0): at scl_fall, addr<=addr+1 and go to RD_REQ. NAK (1): busy=0, go to IDLE.
- Address arithmetic: the increment wraps modulo 2^ADDR_W.
- Write transfers stop only on START/STOP; a partial byte is discarded (no we).
- Simultaneous START and scl edge: START has priority.
- ena=0: the next cycle forces IDLE, sda_oe=0, scl_oe=0, busy=0. Filter continues running.
- Reset mid-transfer: all outputs return to reset values asynchronously. The bus is released immediately.

Test Plan:
- SUBADDR_BYTES=2: START, 0xE0, 0x12, 0x34, 0xAA, 0x55, STOP -> 5 ACKs; we pulses with (addr,wdata) = (0x1234,0xAA) then (0x1235,0x55); busy low after STOP.
- Write sub-address 0x10, repeated START, 0xE1, read 2 bytes (ACK then NAK), rvalid 20 cycles after re -> scl_oe high ≥20 cycles per byte; bytes match rdata; re at addr 0x10 and 0x11; IDLE after NAK.
- Address 0x71 (byte 0xE2) -> no ACK (sda_oe stays 0), no we/re, busy=0.
- rvalid never asserted, STRETCH_MAX=255 -> scl_oe released after 255 cycles, rd_timeout pulses, 0xFF returned.
- SDA glitch of FILTER_LEN-1 cycles while SCL high -> no START/STOP detected; FILTER_LEN cycles -> detected.
- Write from addr 0xFFFF with 2 bytes -> we at 0xFFFF then 0x0000. Assert rst_n low mid-byte -> all outputs 0 immediately; after release, a new START transacts normally.
